// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and the I-cache.
interface fetch_unit_if;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;

    modport master (input ihit, input imemload, output imemREN, output imemaddr);
    modport slave  (output ihit, output imemload, input imemREN, input imemaddr);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues I-memory reads and fills IF/ID.
// Optional HALT handling is compiled in with `define FETCH_HALT_EN.
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic                CLK,
    input  logic                nRST,
    fetch_unit_if.master        imem,
    input  logic                hazard,
    input  logic                dstall,
    input  logic                branch,
    input  logic                jump,
    input  logic [31:0]         branch_target,
    input  logic [31:0]         jump_target,
    output logic [31:0]         ifid_instr,
    output logic [31:0]         ifid_npc,
    output logic                ifid_valid,
    output logic                halted
);

    typedef enum logic [1:0] {FETCH = 2'd0, DROP = 2'd1, HALT = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_p0, pc_nxt;
    logic [31:0] redir_pc, redir_nxt;
    logic [31:0] instr_nxt, npc_nxt;
    logic        valid_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] tgt;
    logic        is_halt;

    assign pc_plus4 = pc_p0 + 32'd4;
    // Jump outranks branch; targets are word-aligned on the way into the PC.
    assign tgt = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;

`ifdef FETCH_HALT_EN
    assign is_halt = (imem.imemload[31:26] == 6'h3F);
`else
    assign is_halt = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // IF/ID boundary: PC, pending redirect target and the IF/ID register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_p0      <= PC_INIT;
            redir_pc   <= 32'h0;
            ifid_instr <= 32'h0;
            ifid_npc   <= 32'h0;
            ifid_valid <= 1'b0;
        end else begin
            pc_p0      <= pc_nxt;
            redir_pc   <= redir_nxt;
            ifid_instr <= instr_nxt;
            ifid_npc   <= npc_nxt;
            ifid_valid <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        redir_nxt = redir_pc;
        instr_nxt = ifid_instr;
        npc_nxt   = ifid_npc;
        valid_nxt = ifid_valid;
        unique case (state)
            FETCH: begin
                // Stale operands under a hazard: redirects wait until it clears.
                if (!dstall && !hazard) begin
                    if (jump || branch) begin
                        instr_nxt = 32'h0;
                        valid_nxt = 1'b0;
                        if (imem.ihit) begin
                            pc_nxt = tgt;
                        end else begin
                            redir_nxt = tgt;
                            state_nxt = DROP;
                        end
                    end else if (imem.ihit) begin
                        instr_nxt = imem.imemload;
                        npc_nxt   = pc_plus4;
                        valid_nxt = 1'b1;
                        if (is_halt) begin
                            state_nxt = HALT;
                        end else begin
                            pc_nxt = pc_plus4;
                        end
                    end
                end
            end
            DROP: begin
                // The outstanding miss must complete before the new address is issued.
                if (!dstall && imem.ihit) begin
                    pc_nxt    = redir_pc;
                    state_nxt = FETCH;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_comb begin
        imem.imemREN  = (state != HALT);
        imem.imemaddr = pc_p0;
`ifdef FETCH_HALT_EN
        halted        = (state == HALT);
`else
        halted        = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized control traffic,
// compared each cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] PC_INIT_TB = 32'h0000_0100;

    logic        clk;
    logic        rst_n;
    logic        hazard, dstall, branch, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] ifid_instr, ifid_npc;
    logic        ifid_valid, halted;

    fetch_unit_if imem ();

    fetch_unit #(.PC_INIT(PC_INIT_TB)) dut (
        .CLK           (clk),
        .nRST          (rst_n),
        .imem          (imem.master),
        .hazard        (hazard),
        .dstall        (dstall),
        .branch        (branch),
        .jump          (jump),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .ifid_instr    (ifid_instr),
        .ifid_npc      (ifid_npc),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Behavioural model of the fetch stage
    logic [31:0] m_pc, m_redir, m_instr, m_npc;
    logic        m_valid, m_drop, m_halt;
    logic        use_ovr;
    logic [31:0] ovr_word;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return {6'h01, a[25:0] ^ 26'h2A5_5A5A};
    endfunction

    task automatic model_reset();
        m_pc = PC_INIT_TB; m_redir = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
        m_valid = 1'b0; m_drop = 1'b0; m_halt = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] t;
        logic        halt_op;
`ifdef FETCH_HALT_EN
        halt_op = (imem.imemload[31:26] == 6'h3F);
`else
        halt_op = 1'b0;
`endif
        if (m_halt) begin
            // stopped until reset
        end else if (m_drop) begin
            if (imem.ihit && !dstall) begin
                m_pc   = m_redir;
                m_drop = 1'b0;
            end
        end else if (dstall || hazard) begin
            // frozen
        end else if (jump || branch) begin
            t = jump ? jump_target : branch_target;
            t[1:0] = 2'b00;
            m_instr = 32'h0;
            m_valid = 1'b0;
            if (imem.ihit) m_pc = t;
            else begin
                m_redir = t;
                m_drop  = 1'b1;
            end
        end else if (imem.ihit) begin
            m_instr = imem.imemload;
            m_npc   = m_pc + 32'd4;
            m_valid = 1'b1;
            if (halt_op) m_halt = 1'b1;
            else m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imemaddr"}, imem.imemaddr, m_pc);
        check({tag, ".imemREN"}, {31'h0, imem.imemREN}, {31'h0, !m_halt});
        check({tag, ".ifid_instr"}, ifid_instr, m_instr);
        check({tag, ".ifid_valid"}, {31'h0, ifid_valid}, {31'h0, m_valid});
        check({tag, ".halted"}, {31'h0, halted}, {31'h0, m_halt});
        if (m_valid) check({tag, ".ifid_npc"}, ifid_npc, m_npc);
    endtask

    task automatic cycle(input string tag);
        imem.imemload = use_ovr ? ovr_word : memword(m_pc);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_ctl(input logic h, input logic d, input logic b, input logic j, input logic ih);
        hazard = h; dstall = d; branch = b; jump = j; imem.ihit = ih;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        use_ovr = 1'b0; ovr_word = 32'h0;
        branch_target = 32'h0; jump_target = 32'h0;
        imem.imemload = 32'h0;
        set_ctl(0, 0, 0, 0, 0);

        do_reset();
        check("reset_addr", imem.imemaddr, 32'h100);

        // Sequential fetch with a hit every cycle
        set_ctl(0, 0, 0, 0, 1);
        cycle("seq0");
        check("seq0_npc", ifid_npc, 32'h104);
        check("seq0_addr", imem.imemaddr, 32'h104);
        cycle("seq1");
        check("seq1_npc", ifid_npc, 32'h108);
        check("seq1_addr", imem.imemaddr, 32'h108);

        // Two-cycle data hazard at 0x108, then resume
        set_ctl(1, 0, 0, 0, 1);
        cycle("haz0");
        cycle("haz1");
        check("haz_hold", imem.imemaddr, 32'h108);
        set_ctl(0, 0, 0, 0, 1);
        cycle("haz_resume");
        check("haz_resume_npc", ifid_npc, 32'h10C);
        check("haz_resume_instr", ifid_instr, memword(32'h108));

        // Taken branch with a hit
        branch_target = 32'h200;
        set_ctl(0, 0, 1, 0, 1);
        cycle("br_hit");
        check("br_hit_addr", imem.imemaddr, 32'h200);
        check("br_hit_valid", {31'h0, ifid_valid}, 32'h0);

        // Jump during a miss; later redirects in DROP are ignored
        jump_target = 32'h40;
        set_ctl(0, 0, 0, 1, 0);
        cycle("jmp_miss0");
        jump_target = 32'h80;
        cycle("jmp_miss1");
        set_ctl(0, 0, 1, 0, 0);
        cycle("jmp_miss2");
        check("jmp_miss_addr", imem.imemaddr, 32'h200);
        set_ctl(0, 0, 0, 0, 1);
        cycle("jmp_done");
        check("jmp_done_addr", imem.imemaddr, 32'h40);
        check("jmp_done_valid", {31'h0, ifid_valid}, 32'h0);
        cycle("jmp_next");

        // Hazard beats branch; branch taken once the hazard drops
        branch_target = 32'h301;
        set_ctl(1, 0, 1, 0, 1);
        cycle("hzbr0");
        check("hzbr0_addr", imem.imemaddr, 32'h44);
        set_ctl(0, 0, 1, 0, 1);
        cycle("hzbr1");
        check("hzbr1_addr", imem.imemaddr, 32'h300);

        // dstall freezes everything, ihit and redirects included
        set_ctl(0, 1, 1, 1, 1);
        cycle("dstall0");
        set_ctl(0, 1, 0, 0, 1);
        cycle("dstall1");
        check("dstall_addr", imem.imemaddr, 32'h300);

        // jump and branch together: jump wins
        jump_target = 32'h10; branch_target = 32'h500;
        set_ctl(0, 0, 1, 1, 1);
        cycle("jmp_wins");
        check("jmp_wins_addr", imem.imemaddr, 32'h10);

        // HALT opcode fetched at 0x10
        use_ovr = 1'b1; ovr_word = 32'hFFFF_FFFF;
        set_ctl(0, 0, 0, 0, 1);
        cycle("halt0");
        use_ovr = 1'b0;
`ifdef FETCH_HALT_EN
        check("halt_addr", imem.imemaddr, 32'h10);
        check("halt_flag", {31'h0, halted}, 32'h1);
`else
        check("halt_addr", imem.imemaddr, 32'h14);
        check("halt_flag", {31'h0, halted}, 32'h0);
`endif
        check("halt_instr", ifid_instr, 32'hFFFF_FFFF);
        cycle("halt1");
        cycle("halt2");

        // Asynchronous reset while a redirect is pending in DROP
        do_reset();
        jump_target = 32'h800;
        set_ctl(0, 0, 0, 1, 0);
        cycle("rst_drop0");
        set_ctl(0, 0, 0, 0, 0);
        cycle("rst_drop1");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        check("async_rst_addr", imem.imemaddr, 32'h100);
        #1;
        rst_n = 1'b1;
        set_ctl(0, 0, 0, 0, 1);
        cycle("post_rst");

        // PC wrap at the top of the address space
        jump_target = 32'hFFFF_FFFF;
        set_ctl(0, 0, 0, 1, 1);
        cycle("wrap_jmp");
        check("wrap_align", imem.imemaddr, 32'hFFFF_FFFC);
        set_ctl(0, 0, 0, 0, 1);
        cycle("wrap_adv");
        check("wrap_addr", imem.imemaddr, 32'h0);

        // Randomized control traffic
        for (int i = 0; i < 400; i++) begin
            set_ctl($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 70);
            branch_target = $urandom;
            jump_target   = $urandom;
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
